// File: rtl/simple_bus.sv
// simple_bus: fixed-priority N-host to M-device bus with one-cycle response routing; define SIMPLE_BUS_DECODE_ERR_EN to flag unmapped accesses with an error
module simple_bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      host_req_i           [NrHosts],
  input  logic                      host_we_i            [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
  output logic                      host_gnt_o           [NrHosts],
  output logic                      host_rvalid_o        [NrHosts],
  output logic                      host_err_o           [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
  output logic                      device_req_o         [NrDevices],
  output logic                      device_we_o          [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
  input  logic                      device_rvalid_i      [NrDevices],
  input  logic                      device_err_i         [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);
  localparam int HW = NrHosts > 1 ? $clog2(NrHosts) : 1;
  localparam int DW = NrDevices > 1 ? $clog2(NrDevices) : 1;
`ifdef SIMPLE_BUS_DECODE_ERR_EN
  localparam logic DecodeErr = 1'b1;
`else
  localparam logic DecodeErr = 1'b0;
`endif
  logic                    any_req, dev_hit, pend_q, hit_q;
  logic [HW-1:0]           host_sel, host_q;
  logic [DW-1:0]           dev_sel, dev_q;
  logic [AddressWidth-1:0] addr;
  logic                    rsp_valid, rsp_err;
  logic [DataWidth-1:0]    rsp_rdata;
  // fixed-priority arbiter: scanning downwards leaves the lowest requesting index selected
  always_comb begin
    any_req  = 1'b0;
    host_sel = '0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      if (host_req_i[i]) begin
        any_req  = 1'b1;
        host_sel = HW'(i);
      end
    end
  end
  assign addr = any_req ? host_addr_i[host_sel] : '0;
  // address decode: lowest matching device wins when windows overlap
  always_comb begin
    dev_hit = 1'b0;
    dev_sel = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dev_hit = 1'b1;
        dev_sel = DW'(d);
      end
    end
  end
  // grant to the winner and broadcast its request to every device, zeroed when idle
  always_comb begin
    for (int i = 0; i < NrHosts; i++) host_gnt_o[i] = any_req && host_sel == HW'(i);
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = any_req && dev_hit && dev_sel == DW'(d);
      device_we_o[d]    = any_req && host_we_i[host_sel];
      device_addr_o[d]  = addr;
      device_be_o[d]    = any_req ? host_be_i[host_sel] : '0;
      device_wdata_o[d] = any_req ? host_wdata_i[host_sel] : '0;
    end
  end
  // remember who was granted and which device (if any) owes the response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      hit_q  <= 1'b0;
      host_q <= '0;
      dev_q  <= '0;
    end else begin
      pend_q <= any_req;
      hit_q  <= dev_hit;
      host_q <= host_sel;
      dev_q  <= dev_sel;
    end
  end
  // unmapped accesses complete on their own; mapped ones relay the device response
  always_comb begin
    rsp_valid = pend_q && (hit_q ? device_rvalid_i[dev_q] : 1'b1);
    rsp_err   = pend_q && (hit_q ? device_err_i[dev_q] : DecodeErr);
    rsp_rdata = (pend_q && hit_q) ? device_rdata_i[dev_q] : '0;
  end
  // steer the response to the owning host only
  always_comb begin
    for (int i = 0; i < NrHosts; i++) begin
      host_rvalid_o[i] = rsp_valid && host_q == HW'(i);
      host_err_o[i]    = rsp_err && host_q == HW'(i);
      host_rdata_o[i]  = host_q == HW'(i) ? rsp_rdata : '0;
    end
  end
endmodule

// File: tb/tb_simple_bus.sv
// tb_simple_bus: directed vector table plus reset corner sequence for simple_bus (2 hosts, 3 devices)
module tb_simple_bus;
  localparam int NH = 2;
  localparam int ND = 3;
`ifdef SIMPLE_BUS_DECODE_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        host_req_i [NH];
  logic        host_we_i [NH];
  logic [31:0] host_addr_i [NH];
  logic [3:0]  host_be_i [NH];
  logic [31:0] host_wdata_i [NH];
  logic        host_gnt_o [NH];
  logic        host_rvalid_o [NH];
  logic        host_err_o [NH];
  logic [31:0] host_rdata_o [NH];
  logic        device_req_o [ND];
  logic        device_we_o [ND];
  logic [31:0] device_addr_o [ND];
  logic [3:0]  device_be_o [ND];
  logic [31:0] device_wdata_o [ND];
  logic        device_rvalid_i [ND];
  logic        device_err_i [ND];
  logic [31:0] device_rdata_i [ND];
  logic [31:0] cfg_base [ND];
  logic [31:0] cfg_mask [ND];
  simple_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_err_o(host_err_o),
    .host_rdata_o(host_rdata_o),
    .device_req_o(device_req_o), .device_we_o(device_we_o), .device_addr_o(device_addr_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_err_i(device_err_i), .device_rdata_i(device_rdata_i),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic [1:0]  req, we;
    logic [31:0] a0, a1, wd0;
    logic [3:0]  be0;
    logic [2:0]  drv, derr;
    logic [1:0]  gnt;
    logic [2:0]  dreq;
    logic        dwe;
    logic [31:0] daddr, dwd;
    logic [3:0]  dbe;
    logic [1:0]  rv, er;
    logic [31:0] rd0, rd1;
  } vec_t;
  vec_t vt [11];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    for (int h = 0; h < NH; h++) begin
      host_req_i[h] = v.req[h];
      host_we_i[h]  = v.we[h];
    end
    host_addr_i[0]  = v.a0;
    host_addr_i[1]  = v.a1;
    host_wdata_i[0] = v.wd0;
    host_wdata_i[1] = 32'h0;
    host_be_i[0]    = v.be0;
    host_be_i[1]    = 4'hF;
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = v.drv[d];
      device_err_i[d]    = v.derr[d];
    end
  endtask
  task automatic check(input int idx, input vec_t v);
    chk("gnt", idx, {30'b0, host_gnt_o[1], host_gnt_o[0]}, {30'b0, v.gnt});
    chk("dev_req", idx, {29'b0, device_req_o[2], device_req_o[1], device_req_o[0]}, {29'b0, v.dreq});
    for (int d = 0; d < ND; d++) begin
      chk("dev_we", idx, {31'b0, device_we_o[d]}, {31'b0, v.dwe});
      chk("dev_addr", idx, device_addr_o[d], v.daddr);
      chk("dev_wdata", idx, device_wdata_o[d], v.dwd);
      chk("dev_be", idx, {28'b0, device_be_o[d]}, {28'b0, v.dbe});
    end
    chk("rvalid", idx, {30'b0, host_rvalid_o[1], host_rvalid_o[0]}, {30'b0, v.rv});
    chk("err", idx, {30'b0, host_err_o[1], host_err_o[0]}, {30'b0, v.er});
    chk("rdata0", idx, host_rdata_o[0], v.rd0);
    chk("rdata1", idx, host_rdata_o[1], v.rd1);
  endtask
  initial begin
    vt[0]  = '{2'b00, 2'b00, 32'h100004, 32'h0, 32'h55, 4'hF, 3'b000, 3'b000,
               2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0, 32'h0};
    vt[1]  = '{2'b01, 2'b00, 32'h100004, 32'h0, 32'h0, 4'hF, 3'b000, 3'b000,
               2'b01, 3'b001, 1'b0, 32'h100004, 32'h0, 4'hF, 2'b00, 2'b00, 32'h0, 32'h0};
    vt[2]  = '{2'b01, 2'b01, 32'h20000, 32'h0, 32'h41, 4'hF, 3'b001, 3'b000,
               2'b01, 3'b010, 1'b1, 32'h20000, 32'h41, 4'hF, 2'b01, 2'b00, 32'hCAFE0000, 32'h0};
    vt[3]  = '{2'b11, 2'b00, 32'h30008, 32'h100010, 32'h0, 4'h3, 3'b010, 3'b000,
               2'b01, 3'b100, 1'b0, 32'h30008, 32'h0, 4'h3, 2'b01, 2'b00, 32'hCAFE0001, 32'h0};
    vt[4]  = '{2'b10, 2'b00, 32'h0, 32'h100010, 32'h0, 4'hF, 3'b100, 3'b100,
               2'b10, 3'b001, 1'b0, 32'h100010, 32'h0, 4'hF, 2'b01, 2'b01, 32'hCAFE0002, 32'h0};
    vt[5]  = '{2'b10, 2'b00, 32'h0, 32'h40000, 32'h0, 4'hF, 3'b001, 3'b000,
               2'b10, 3'b000, 1'b0, 32'h40000, 32'h0, 4'hF, 2'b10, 2'b00, 32'h0, 32'hCAFE0000};
    vt[6]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'hF, 3'b000, 3'b000,
               2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 4'h0, 2'b10, {EXP_ERR, 1'b0}, 32'h0, 32'h0};
    vt[7]  = '{2'b10, 2'b00, 32'h0, 32'h30004, 32'h0, 4'hF, 3'b000, 3'b000,
               2'b10, 3'b100, 1'b0, 32'h30004, 32'h0, 4'hF, 2'b00, 2'b00, 32'h0, 32'h0};
    vt[8]  = '{2'b10, 2'b00, 32'h0, 32'h20400, 32'h0, 4'hF, 3'b100, 3'b100,
               2'b10, 3'b000, 1'b0, 32'h20400, 32'h0, 4'hF, 2'b10, 2'b10, 32'h0, 32'hCAFE0002};
    vt[9]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'hF, 3'b000, 3'b000,
               2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 4'h0, 2'b10, {EXP_ERR, 1'b0}, 32'h0, 32'h0};
    vt[10] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'hF, 3'b000, 3'b000,
               2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0, 32'h0};
    cfg_base[0] = 32'h100000; cfg_mask[0] = ~32'hFFFFF;
    cfg_base[1] = 32'h20000;  cfg_mask[1] = ~32'h3FF;
    cfg_base[2] = 32'h30000;  cfg_mask[2] = ~32'h3FF;
    for (int d = 0; d < ND; d++) device_rdata_i[d] = 32'hCAFE0000 + 32'(d);
    drive(vt[10]);
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_rvalid", 0, {30'b0, host_rvalid_o[1], host_rvalid_o[0]}, 32'h0);
    chk("reset_err", 0, {30'b0, host_err_o[1], host_err_o[0]}, 32'h0);
    chk("reset_gnt", 0, {30'b0, host_gnt_o[1], host_gnt_o[0]}, 32'h0);
    rst_ni = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(vt[i]);
      @(negedge clk_i);
      check(i, vt[i]);
      @(posedge clk_i);
      #1;
    end
    host_req_i[0]  = 1'b1;
    host_addr_i[0] = 32'h100004;
    @(negedge clk_i);
    chk("pre_rst_gnt0", 100, {31'b0, host_gnt_o[0]}, 32'h1);
    @(posedge clk_i);
    #1;
    host_req_i[0]      = 1'b0;
    device_rvalid_i[0] = 1'b1;
    #1;
    chk("pre_rst_rvalid0", 101, {31'b0, host_rvalid_o[0]}, 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("in_rst_rvalid0", 102, {31'b0, host_rvalid_o[0]}, 32'h0);
    chk("in_rst_err0", 102, {31'b0, host_err_o[0]}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_rvalid", 103, {30'b0, host_rvalid_o[1], host_rvalid_o[0]}, 32'h0);
    host_req_i[1]  = 1'b1;
    host_addr_i[1] = 32'h30000;
    #1;
    chk("post_rst_gnt", 104, {30'b0, host_gnt_o[1], host_gnt_o[0]}, 32'h2);
    chk("post_rst_dreq", 104, {29'b0, device_req_o[2], device_req_o[1], device_req_o[0]}, 32'h4);
    @(posedge clk_i);
    #1;
    host_req_i[1]      = 1'b0;
    device_rvalid_i[0] = 1'b0;
    device_rvalid_i[2] = 1'b1;
    #1;
    chk("post_rst_rsp", 105, {30'b0, host_rvalid_o[1], host_rvalid_o[0]}, 32'h2);
    chk("post_rst_rdata1", 105, host_rdata_o[1], 32'hCAFE0002);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
